// File: rtl/counter_sequencer.sv
// Control front-end for the two-digit preloadable up/down display counter.
// Debounces the start/stop/direction pushbuttons, runs the IDLE/LOAD/RUN/PAUSE
// sequence, produces a single-cycle count tick in the clk_50MHz domain and
// counts completed wrap-arounds (laps) for status display.
module counter_sequencer #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TICK_DIV        = 3,
   parameter int MAX_PRELOAD     = 59
) (
   input  logic       clk_50MHz,
   input  logic       rst_n,
   input  logic       key_start_n,
   input  logic       key_stop_n,
   input  logic       key_dir_n,
   input  logic [5:0] sw_preload,
   input  logic [5:0] count_value,
   output logic       cnt_load,
   output logic [5:0] cnt_preload,
   output logic       cnt_ena,
   output logic       cnt_tick,
   output logic       cnt_up,
   output logic [7:0] lap_count,
   output logic [1:0] state
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_PAUSE = 2'd3;

   localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(TICK_DIV - 1);
   localparam logic [5:0]       PRELOAD_MAX = 6'(MAX_PRELOAD);

   // Key bit order everywhere: [0]=start, [1]=stop, [2]=dir.
   logic [2:0]            key_raw;
   logic [2:0]            sync1_q, sync1_d;
   logic [2:0]            sync2_q, sync2_d;
   logic [2:0]            db_lvl_q, db_lvl_d;
   logic [2:0]            db_prev_q, db_prev_d;
   logic [2:0]            press_q, press_d;
   logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

   logic [1:0]       state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             cnt_load_q, cnt_load_d;
   logic [5:0]       cnt_preload_q, cnt_preload_d;
   logic             cnt_ena_q, cnt_ena_d;
   logic             cnt_tick_q, cnt_tick_d;
   logic             cnt_up_q, cnt_up_d;
   logic [7:0]       lap_count_q, lap_count_d;

   logic act_start, act_stop, act_dir, lap_hit;

   function automatic logic [5:0] clamp_preload(input logic [5:0] v);
      return (v > PRELOAD_MAX) ? PRELOAD_MAX : v;
   endfunction

   assign key_raw = {key_dir_n, key_stop_n, key_start_n};

   // Key path: two-flop synchronizer, stability counter, press edge detect.
   always_comb begin
      sync1_d   = key_raw;
      sync2_d   = sync1_q;
      db_lvl_d  = db_lvl_q;
      db_cnt_d  = db_cnt_q;
      for (int i = 0; i < 3; i++) begin
         if (sync2_q[i] == db_lvl_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == DB_LAST) begin
            db_lvl_d[i] = sync2_q[i];
            db_cnt_d[i] = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
         end
      end
      // Press fires one cycle after the debounced level falls; releases are silent.
      db_prev_d = db_lvl_q;
      press_d   = db_prev_q & ~db_lvl_q;
   end

   // Sequencer: key priority stop > start > dir, divider, tick and lap counting.
   always_comb begin
      act_stop  = press_q[1];
      act_start = press_q[0] & ~press_q[1];
      act_dir   = press_q[2] & ~press_q[1] & ~press_q[0];

      state_d       = state_q;
      div_d         = div_q;
      cnt_up_d      = cnt_up_q;
      cnt_preload_d = cnt_preload_q;
      lap_count_d   = lap_count_q;

      case (state_q)
         S_IDLE: begin
            if (act_start) state_d = S_LOAD;
         end
         S_LOAD: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (act_stop)       state_d = S_IDLE;
            else if (act_start) state_d = S_PAUSE;
            if (act_dir)        cnt_up_d = ~cnt_up_q;
         end
         default: begin
            if (act_stop)       state_d = S_IDLE;
            else if (act_start) state_d = S_RUN;
            if (act_dir)        cnt_up_d = ~cnt_up_q;
         end
      endcase

      // Divider only advances across RUN->RUN edges, so it freezes on the
      // edge into PAUSE and resumes from the same phase.
      if (state_d == S_IDLE || state_d == S_LOAD) begin
         div_d = '0;
      end else if (state_q == S_RUN && state_d == S_RUN) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      end

      cnt_tick_d = (state_q == S_RUN) && (state_d == S_RUN) && (div_q == DIV_LAST);
      cnt_load_d = (state_d == S_LOAD);
      cnt_ena_d  = (state_d == S_RUN);

      // Lap uses the direction in force during the tick, not a same-cycle toggle.
      lap_hit = (cnt_preload_q == 6'd0) ||
                (cnt_up_q ? (count_value == cnt_preload_q) : (count_value == 6'd0));
      if (cnt_tick_q && lap_hit && lap_count_q != 8'hFF) begin
         lap_count_d = lap_count_q + 8'd1;
      end

      // Preload is captured on entry to LOAD so the counter sees it with cnt_load.
      if (state_d == S_LOAD) begin
         cnt_preload_d = clamp_preload(sw_preload);
         lap_count_d   = 8'd0;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_50MHz) begin
      if (!rst_n) begin
         sync1_q       <= 3'b111;
         sync2_q       <= 3'b111;
         db_lvl_q      <= 3'b111;
         db_prev_q     <= 3'b111;
         press_q       <= 3'b000;
         db_cnt_q      <= '0;
         state_q       <= S_IDLE;
         div_q         <= '0;
         cnt_load_q    <= 1'b0;
         cnt_preload_q <= 6'd0;
         cnt_ena_q     <= 1'b0;
         cnt_tick_q    <= 1'b0;
         cnt_up_q      <= 1'b1;
         lap_count_q   <= 8'd0;
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         db_lvl_q      <= db_lvl_d;
         db_prev_q     <= db_prev_d;
         press_q       <= press_d;
         db_cnt_q      <= db_cnt_d;
         state_q       <= state_d;
         div_q         <= div_d;
         cnt_load_q    <= cnt_load_d;
         cnt_preload_q <= cnt_preload_d;
         cnt_ena_q     <= cnt_ena_d;
         cnt_tick_q    <= cnt_tick_d;
         cnt_up_q      <= cnt_up_d;
         lap_count_q   <= lap_count_d;
      end
   end

   assign cnt_load    = cnt_load_q;
   assign cnt_preload = cnt_preload_q;
   assign cnt_ena     = cnt_ena_q;
   assign cnt_tick    = cnt_tick_q;
   assign cnt_up      = cnt_up_q;
   assign lap_count   = lap_count_q;
   assign state       = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Testbench for counter_sequencer (DEBOUNCE_CYCLES=4, TICK_DIV=3, MAX_PRELOAD=59).
// Table of held-input steps followed by hand-written multi-cycle sequences.
module tb_counter_sequencer;

   localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, PAUSE = 2'd3;

   logic       clk_50MHz = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_start_n = 1'b1, key_stop_n = 1'b1, key_dir_n = 1'b1;
   logic [5:0] sw_preload = 6'd0;
   logic [5:0] count_value;
   logic       cnt_load, cnt_ena, cnt_tick, cnt_up;
   logic [5:0] cnt_preload;
   logic [7:0] lap_count;
   logic [1:0] state;

   // External counter: either the bench model or a forced constant.
   logic       cv_force_en = 1'b1;
   logic [5:0] cv_force = 6'd63;
   logic [5:0] model_q = 6'd0;

   int n_pass = 0;
   int n_total = 0;

   counter_sequencer #(.DEBOUNCE_CYCLES(4), .TICK_DIV(3), .MAX_PRELOAD(59)) dut (
      .clk_50MHz  (clk_50MHz),
      .rst_n      (rst_n),
      .key_start_n(key_start_n),
      .key_stop_n (key_stop_n),
      .key_dir_n  (key_dir_n),
      .sw_preload (sw_preload),
      .count_value(count_value),
      .cnt_load   (cnt_load),
      .cnt_preload(cnt_preload),
      .cnt_ena    (cnt_ena),
      .cnt_tick   (cnt_tick),
      .cnt_up     (cnt_up),
      .lap_count  (lap_count),
      .state      (state)
   );

   always #10 clk_50MHz = ~clk_50MHz;

   assign count_value = cv_force_en ? cv_force : model_q;

   // Two-digit counter model driven by the sequencer outputs.
   always @(posedge clk_50MHz) begin
      if (cnt_load)
         model_q <= cnt_up ? 6'd0 : cnt_preload;
      else if (cnt_tick) begin
         if (cnt_up) model_q <= (model_q == cnt_preload) ? 6'd0 : model_q + 6'd1;
         else        model_q <= (model_q == 6'd0) ? cnt_preload : model_q - 6'd1;
      end
   end

   typedef struct {
      string      name;
      logic       rstn;
      logic       ks, kp, kd;
      logic [5:0] sw;
      int         cyc;
      logic [1:0] st;
      logic       ena;
      logic       up;
      logic [7:0] lap;
      logic [5:0] pre;
   } vec_t;

   vec_t vq[$];

   task automatic add(input string n, input logic rstn, input logic ks, input logic kp,
                      input logic kd, input logic [5:0] sw, input int cyc, input logic [1:0] st,
                      input logic ena, input logic up, input logic [7:0] lap, input logic [5:0] pre);
      vec_t v;
      v.name = n; v.rstn = rstn; v.ks = ks; v.kp = kp; v.kd = kd; v.sw = sw; v.cyc = cyc;
      v.st = st; v.ena = ena; v.up = up; v.lap = lap; v.pre = pre;
      vq.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic hold_keys(input logic s, input logic p, input logic d, input int n);
      key_start_n = s; key_stop_n = p; key_dir_n = d;
      repeat (n) @(negedge clk_50MHz);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int   n, k, loads;
      bit   found;

      //   name            rst ks kp kd  sw cyc  state ena up lap pre
      add("reset",          0, 1, 1, 1,  5,  3, IDLE, 0, 1, 0, 0);
      add("idle_quiet",     1, 1, 1, 1,  5,  4, IDLE, 0, 1, 0, 0);
      add("idle_stop_ign",  1, 1, 0, 1,  5, 10, IDLE, 0, 1, 0, 0);
      add("idle_rel1",      1, 1, 1, 1,  5, 10, IDLE, 0, 1, 0, 0);
      add("idle_dir_ign",   1, 1, 1, 0,  5, 10, IDLE, 0, 1, 0, 0);
      add("idle_rel2",      1, 1, 1, 1,  9, 10, IDLE, 0, 1, 0, 0);
      add("start_run",      1, 0, 1, 1,  9, 10, RUN,  1, 1, 0, 9);
      add("run_rel1",       1, 1, 1, 1,  9, 10, RUN,  1, 1, 0, 9);
      add("run_dir",        1, 1, 1, 0,  9, 10, RUN,  1, 0, 0, 9);
      add("run_rel2",       1, 1, 1, 1,  9, 10, RUN,  1, 0, 0, 9);
      add("pause",          1, 0, 1, 1, 33, 10, PAUSE,0, 0, 0, 9);
      add("pause_rel1",     1, 1, 1, 1, 33, 10, PAUSE,0, 0, 0, 9);
      add("pause_dir",      1, 1, 1, 0, 33, 10, PAUSE,0, 1, 0, 9);
      add("pause_rel2",     1, 1, 1, 1, 33, 10, PAUSE,0, 1, 0, 9);
      add("resume",         1, 0, 1, 1, 33, 10, RUN,  1, 1, 0, 9);
      add("resume_rel",     1, 1, 1, 1, 33, 10, RUN,  1, 1, 0, 9);
      add("run_stop",       1, 1, 0, 1, 33, 10, IDLE, 0, 1, 0, 9);
      add("stop_rel",       1, 1, 1, 1, 63, 10, IDLE, 0, 1, 0, 9);
      add("clamp_63",       1, 0, 1, 1, 63, 10, RUN,  1, 1, 0, 59);
      add("clamp_rel",      1, 1, 1, 1, 63, 10, RUN,  1, 1, 0, 59);
      add("run_dir2",       1, 1, 1, 0, 63, 10, RUN,  1, 0, 0, 59);
      add("run_dir2_rel",   1, 1, 1, 1, 63, 10, RUN,  1, 0, 0, 59);
      add("reset_mid_run",  0, 1, 1, 1, 63,  1, IDLE, 0, 1, 0, 0);
      add("post_reset",     1, 1, 1, 1, 63, 10, IDLE, 0, 1, 0, 0);

      for (int i = 0; i < vq.size(); i++) begin
         rst_n = vq[i].rstn;
         key_start_n = vq[i].ks; key_stop_n = vq[i].kp; key_dir_n = vq[i].kd;
         sw_preload = vq[i].sw;
         repeat (vq[i].cyc) @(negedge clk_50MHz);
         check({vq[i].name, ".state"},   state,       vq[i].st);
         check({vq[i].name, ".ena"},     cnt_ena,     vq[i].ena);
         check({vq[i].name, ".up"},      cnt_up,      vq[i].up);
         check({vq[i].name, ".lap"},     lap_count,   vq[i].lap);
         check({vq[i].name, ".preload"}, cnt_preload, vq[i].pre);
         check({vq[i].name, ".load"},    cnt_load,    0);
         if (vq[i].st != RUN) check({vq[i].name, ".tick"}, cnt_tick, 0);
      end

      // Start latency: LOAD on edge 8 after the raw edge, first tick 4 later, then every 3.
      cv_force_en = 1'b0;
      sw_preload = 6'd5;
      key_start_n = 1'b0;
      for (int kk = 1; kk <= 20; kk++) begin
         @(negedge clk_50MHz);
         check($sformatf("lat_state_%0d", kk), state,
               (kk < 8) ? IDLE : (kk == 8) ? LOAD : RUN);
         check($sformatf("lat_load_%0d", kk), cnt_load, (kk == 8) ? 1 : 0);
         if (kk == 9) check("lat_preload", cnt_preload, 5);
         if (kk >= 9) check($sformatf("lat_tick_%0d", kk), cnt_tick,
                            (kk >= 12 && (kk - 12) % 3 == 0) ? 1 : 0);
      end
      hold_keys(1, 1, 1, 10);
      hold_keys(1, 0, 1, 10);
      hold_keys(1, 1, 1, 10);
      check("lat_stop_idle", state, IDLE);

      // Clamp and laps: preload 63 -> 59, a lap every 60 ticks.
      sw_preload = 6'd63;
      key_start_n = 1'b0;
      found = 0;
      for (int kk = 0; kk < 20 && !found; kk++) begin
         @(negedge clk_50MHz);
         if (state == LOAD) found = 1;
      end
      check("clamp_load_seen", found, 1);
      n = 0; k = 0;
      while (n < 120 && k < 600) begin
         @(negedge clk_50MHz);
         k++;
         if (k == 5) key_start_n = 1'b1;
         if (cnt_tick) begin
            n++;
            if (n == 60 || n == 120) begin
               check($sformatf("lap_before_%0d", n), lap_count, n / 60 - 1);
               @(negedge clk_50MHz);
               k++;
               check($sformatf("lap_after_%0d", n), lap_count, n / 60);
            end
         end
      end
      check("lap_ticks_seen", n, 120);
      check("clamp_preload", cnt_preload, 59);

      // Stop from RUN: IDLE keeps preload, direction and lap count.
      hold_keys(1, 0, 1, 10);
      hold_keys(1, 1, 1, 10);
      check("stop_state", state, IDLE);
      check("stop_lap_hold", lap_count, 2);
      check("stop_pre_hold", cnt_preload, 59);
      check("stop_ena", cnt_ena, 0);
      check("stop_tick", cnt_tick, 0);

      // Bounce: three 1-cycle low glitches give nothing; a clean press gives one LOAD.
      sw_preload = 6'd20;
      loads = 0;
      for (int i = 0; i < 6; i++) begin
         key_start_n = (i % 2 == 0) ? 1'b0 : 1'b1;
         @(negedge clk_50MHz);
         loads += int'(cnt_load);
      end
      key_start_n = 1'b1;
      repeat (20) begin @(negedge clk_50MHz); loads += int'(cnt_load); end
      check("bounce_loads", loads, 0);
      check("bounce_state", state, IDLE);
      loads = 0;
      key_start_n = 1'b0;
      repeat (10) begin @(negedge clk_50MHz); loads += int'(cnt_load); end
      key_start_n = 1'b1;
      repeat (20) begin @(negedge clk_50MHz); loads += int'(cnt_load); end
      check("clean_loads", loads, 1);
      check("clean_state", state, RUN);
      check("clean_lap_cleared", lap_count, 0);
      check("clean_preload", cnt_preload, 20);

      // Pause with divider at 1, then resume: next tick 2 cycles after RUN re-entry.
      found = 0;
      for (int kk = 0; kk < 10 && !found; kk++) begin
         @(negedge clk_50MHz);
         if (cnt_tick) found = 1;
      end
      check("pause_tick_seen", found, 1);
      key_start_n = 1'b0;
      repeat (8) @(negedge clk_50MHz);
      check("pause_state", state, PAUSE);
      check("pause_ena", cnt_ena, 0);
      n = 0;
      for (int kk = 0; kk < 50; kk++) begin
         if (kk == 5) key_start_n = 1'b1;
         @(negedge clk_50MHz);
         n += int'(cnt_tick);
      end
      check("pause_no_ticks", n, 0);
      check("pause_still", state, PAUSE);
      key_start_n = 1'b0;
      for (int kk = 1; kk <= 10; kk++) begin
         @(negedge clk_50MHz);
         if (kk == 8) check("resume_state", state, RUN);
         if (kk >= 8) check($sformatf("resume_tick_%0d", kk), cnt_tick, (kk == 10) ? 1 : 0);
      end
      hold_keys(1, 1, 1, 10);

      // Stop and start in the same cycle: stop wins.
      hold_keys(0, 0, 1, 10);
      check("prio_stop_start", state, IDLE);
      hold_keys(1, 1, 1, 10);

      // Direction toggle in PAUSE, then a down lap at count_value 0.
      hold_keys(0, 1, 1, 10);
      hold_keys(1, 1, 1, 10);
      check("dn_run", state, RUN);
      check("dn_up_before", cnt_up, 1);
      hold_keys(0, 1, 1, 10);
      hold_keys(1, 1, 1, 10);
      check("dn_pause", state, PAUSE);
      hold_keys(1, 1, 0, 10);
      check("dn_up_after", cnt_up, 0);
      hold_keys(1, 1, 1, 10);
      key_start_n = 1'b0;
      found = 0;
      for (int kk = 0; kk < 100 && !found; kk++) begin
         @(negedge clk_50MHz);
         if (kk == 10) key_start_n = 1'b1;
         if (cnt_tick && count_value == 6'd0) found = 1;
      end
      check("dn_zero_tick_seen", found, 1);
      check("dn_lap_before", lap_count, 0);
      @(negedge clk_50MHz);
      check("dn_lap_after", lap_count, 1);
      key_start_n = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
